// File: rtl/ifft_frame_unloader.sv
// IFFT output unloader: checks frame framing on the AXI-Stream beat channel, buffers
// real samples in a FIFO and releases one per audio strobe via a prime/play machine.
module ifft_frame_unloader #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [3:0]          frameSize,
    input  logic [2*DATA_W-1:0] sTData,
    input  logic                sTValid,
    input  logic                sTLast,
    output logic                sTReady,
    input  logic                sampleStrobe,
    output logic [DATA_W-1:0]   sampleOut,
    output logic                sampleValid,
    output logic                frameDone,
    output logic                lastEarly,
    output logic                lastMissing,
    output logic                underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] HALF_CNT = (AW + 1)'(FIFO_DEPTH / 2);

    typedef enum logic {
        PRIME,
        PLAY
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [11:0]       beat_cnt;
    logic [3:0]        n_log2;

    logic        push;
    logic        pop;
    logic [3:0]  eff_log2;
    logic [12:0] frame_len;
    logic [11:0] last_idx;
    logic        at_last;
    logic        unused_imag;

    function automatic logic [3:0] clamp_size(input logic [3:0] fs);
        if (fs < 4'd3)
            return 4'd3;
        else if (fs > 4'd12)
            return 4'd12;
        else
            return fs;
    endfunction

    assign unused_imag = ^sTData[2*DATA_W-1:DATA_W];

    // Ready comes from the registered count, so a pop never frees room in the same cycle.
    assign sTReady = RST_N & (count != FULL_CNT);
    assign push    = sTValid & sTReady;
    assign pop     = (state == PLAY) & sampleStrobe & (count != '0);

    // The first beat of a frame is judged against the size being latched with it.
    assign eff_log2  = (beat_cnt == '0) ? clamp_size(frameSize) : n_log2;
    assign frame_len = 13'd1 << eff_log2;
    assign last_idx  = 12'(frame_len - 13'd1);
    assign at_last   = (beat_cnt == last_idx);

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= sTData[DATA_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= PRIME;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            beat_cnt    <= '0;
            n_log2      <= 4'd3;
            sampleOut   <= '0;
            sampleValid <= 1'b0;
            frameDone   <= 1'b0;
            lastEarly   <= 1'b0;
            lastMissing <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sampleValid <= sampleStrobe;
            frameDone   <= 1'b0;
            lastEarly   <= 1'b0;
            lastMissing <= 1'b0;
            underrun    <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (beat_cnt == '0)
                    n_log2 <= clamp_size(frameSize);
                if (at_last) begin
                    frameDone   <= 1'b1;
                    lastMissing <= ~sTLast;
                    beat_cnt    <= '0;
                end else if (sTLast) begin
                    frameDone <= 1'b1;
                    lastEarly <= 1'b1;
                    beat_cnt  <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 12'd1;
                end
            end

            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            unique case (state)
                PRIME: begin
                    if (sampleStrobe)
                        sampleOut <= '0;
                    if (count >= HALF_CNT)
                        state <= PLAY;
                end
                PLAY: begin
                    if (sampleStrobe) begin
                        if (count != '0) begin
                            sampleOut <= mem[rd_ptr];
                        end else begin
                            sampleOut <= '0;
                            underrun  <= 1'b1;
                            state     <= PRIME;
                        end
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

endmodule

// File: doc/ifft_frame_unloader.md
# ifft_frame_unloader

Downstream stage of the IFFT in the synthesis path: consumes the IFFT core's AXI-Stream output data channel, validates frame boundaries against the configured frame size, buffers the real part of each time-domain sample in an internal FIFO, and releases one sample per audio sample strobe to the output/DAC stage. An output-side prime/play state machine hides start-up latency and recovers from underruns with silence instead of glitches.

## Interface
- DATA_W, 16: width of real/imag components and of the output sample.
- FIFO_DEPTH, 16: sample FIFO depth; power of two, ≥4.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- frameSize  in  4  log2 of IFFT frame length N; same encoding as the IFFT config channel; legal 3..12, values <3 treated as 3, >12 as 12.
- sTData  in  2*DATA_W  IFFT output beat; [DATA_W-1:0] real (two's complement), upper half imag (discarded).
- sTValid  in  1  beat valid.
- sTLast  in  1  last beat of frame, from IFFT core.
- sTReady  out  1  beat accept.
- sampleStrobe  in  1  one-cycle audio-rate request pulse.
- sampleOut  out  DATA_W  current output sample.
- sampleValid  out  1  one-cycle pulse: sampleOut updated.
- frameDone  out  1  one-cycle pulse per completed input frame.
- lastEarly  out  1  one-cycle pulse: sTLast before beat N-1.
- lastMissing  out  1  one-cycle pulse: beat N-1 without sTLast.
- underrun  out  1  one-cycle pulse: strobe in PLAY with empty FIFO.

## Operation
- Reset values: sTReady 0 during reset, sampleOut 0, all pulses 0, FIFO empty, beat counter 0, output FSM PRIME, latched N = 8.
- Accept: beat transfers when sTValid & sTReady. sTReady = !full, from registered FIFO count (no push on a full cycle even if a pop occurs that cycle).
- Frame size: latched when beat counter is 0 and a beat is accepted; changes to frameSize mid-frame ignored until next frame.
- Beat counter: increments per accepted beat. On accepted beat:
  - counter == N-1 and sTLast: frameDone, counter → 0.
  - counter == N-1 and !sTLast: lastMissing and frameDone, counter → 0.
  - counter < N-1 and sTLast: lastEarly and frameDone, counter → 0.
  - Beat is always written to FIFO regardless of framing errors.
- Output FSM:
  - PRIME: strobe → sampleOut = 0, sampleValid pulse, no pop, no underrun. Move to PLAY when FIFO count ≥ FIFO_DEPTH/2 (checked every cycle).
  - PLAY: strobe with FIFO non-empty → pop head into sampleOut, sampleValid pulse. Strobe with FIFO empty → sampleOut = 0, sampleValid and underrun pulses, go to PRIME.
- Simultaneous push and pop: both happen; count unchanged. Pop of an entry pushed the same cycle not allowed (empty check uses registered count).
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: FIFO flushed, counter 0, FSM PRIME; partial frame discarded.

## Timing
- Beat accepted cycle t → in FIFO at t+1; strobe at t+1 or later can pop it.
- Strobe at cycle s → sampleOut/sampleValid registered, visible s+1.
- Framing pulses (frameDone, lastEarly, lastMissing) visible cycle after accepting beat.
- underrun visible cycle after strobe; FSM in PRIME same cycle.
- sTReady deasserts cycle after count reaches FIFO_DEPTH; reasserts cycle after first pop from full.
- Sustained throughput: one beat per cycle while not full.

## Test plan
- frameSize=3, 8 beats real 1..8, sTLast on 8th, strobes every 4 cycles → frameDone once; first strobes give 0 until count ≥8, then outputs 1..8 in order, no error pulses.
- Stream 24 beats, no strobes, FIFO_DEPTH=16 → sTReady low after 16th accept, 16 stored; one strobe → sTReady high next cycle, 17th beat accepted.
- frameSize=4, sTLast on beat 10 → lastEarly + frameDone after beat 10; next 16-beat frame with sTLast on 16 → clean frameDone.
- frameSize=3, 8 beats without sTLast → lastMissing + frameDone after beat 8; frameSize change mid-frame 3→5 takes effect only on the following frame (32 beats).
- In PLAY, drain FIFO, strobe once more → sampleOut 0, underrun pulse, FSM PRIME; refill to 8 → PLAY resumes with correct data.
- Assert RST_N low mid-frame with 5 samples buffered → next cycle all outputs at reset values, FIFO empty; new frame frames correctly from beat 0.
